bsg_cover_drain: RTL

//  Reader/consumer for realigned coverage vectors: captures each valid, cycle-aligned

---
 rtl/bsg_cover_drain_if.sv | 11 +
 rtl/bsg_cover_drain.sv | 68 ++++++
 2 files changed

// File: rtl/bsg_cover_drain_if.sv
// bsg_cover_drain_if: sample input, word output and drop pulse of the coverage drain
interface bsg_cover_drain_if #(
  parameter int num_p = 100,
  parameter int word_width_p = 32
);
  logic v_i, ready_and_i, v_o, drop_o;
  logic [num_p-1:0] data_i;
  logic [word_width_p-1:0] data_o;
  modport master (output v_i, data_i, ready_and_i, input v_o, data_o, drop_o);
  modport slave (input v_i, data_i, ready_and_i, output v_o, data_o, drop_o);
endinterface

// File: rtl/bsg_cover_drain.sv
// bsg_cover_drain: buffers coverage samples and drains each as a header word plus data words
module bsg_cover_drain #(
  parameter int id_p = 0,
  parameter int num_p = 100,
  parameter int word_width_p = 32,
  parameter int els_p = 2
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_cover_drain_if.slave io
);
  localparam int words_lp = (num_p + word_width_p - 1) / word_width_p;
  localparam int kw_lp = words_lp > 1 ? $clog2(words_lp) : 1;
  localparam int pw_lp = $clog2(els_p);
  localparam int cw_lp = $clog2(els_p + 1);
  typedef enum logic [1:0] {s_idle, s_hdr, s_data} state_e;
  state_e state_r, state_n;
  logic [num_p-1:0] mem [els_p];
  logic [pw_lp-1:0] wr_ptr, rd_ptr;
  logic [cw_lp-1:0] cnt;
  logic [kw_lp-1:0] k;
  logic [7:0] drop_cnt;
  logic [15:0] seq;
  logic [words_lp*word_width_p-1:0] padded;
  logic hs, hdr_hs, last, deq, full, enq, drop, drop_r;
  assign hs = io.v_o & io.ready_and_i;
  assign hdr_hs = hs & (state_r == s_hdr);
  assign last = k == kw_lp'(words_lp - 1);
  assign deq = hs & (state_r == s_data) & last;
  assign full = cnt == cw_lp'(els_p);
  assign enq = io.v_i & (~full | deq);
  assign drop = io.v_i & full & ~deq;
  assign io.drop_o = drop_r;
  always_comb begin
    padded = '0;
    padded[num_p-1:0] = mem[rd_ptr];
    io.v_o = state_r != s_idle;
    io.data_o = '0;
    if (state_r == s_hdr) io.data_o[31:0] = {8'(id_p), drop_cnt, seq};
    else if (state_r == s_data) io.data_o = padded[word_width_p*k +: word_width_p];
    state_n = state_r == s_idle ? ((enq | cnt != '0) ? s_hdr : s_idle)
            : state_r == s_hdr ? (hs ? s_data : s_hdr)
            : deq ? ((enq | cnt > cw_lp'(1)) ? s_hdr : s_idle) : state_r;
  end
  always_ff @(posedge clk_i) if (enq) mem[wr_ptr] <= io.data_i;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= s_idle;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      k <= '0;
      drop_cnt <= '0;
      seq <= '0;
      drop_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (enq) wr_ptr <= wr_ptr == pw_lp'(els_p - 1) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr == pw_lp'(els_p - 1) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + cw_lp'(enq) - cw_lp'(deq);
      if (hs & state_r == s_data) k <= last ? '0 : k + 1'b1;
      if (hdr_hs) drop_cnt <= {7'b0, drop};
      else if (drop & drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (hdr_hs) seq <= seq + 16'd1;
      drop_r <= drop;
    end
  end
endmodule
